dm_bridge: RTL and testbench
============================

DM_BRIDGE -- requirements
Module: dm_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports named clk and rst as elsewhere in the CPU, with rst low meaning reset.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 req  in  1  CPU access request, sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores use 000/001/010 only).
REQ-007 addr  in  32  byte address.
REQ-008 wdata  in  32  store data, lane-0 justified.
REQ-009 rdata  out  32  extended load result, registered.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 misalign  out  1  error flag, valid only while done=1.
REQ-013 mem_write  out  1  word write strobe to DM.
REQ-014 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-015 mem_wdata  out  32  word write data.
REQ-016 mem_rdata  in  32  DM read data, valid one cycle after mem_addr is presented.

Function
REQ-017 FSM states SHALL be IDLE, RD, CAP, WR, DONE; DONE always returns to IDLE next cycle.
REQ-018 Acceptance SHALL occur at the edge where state=IDLE and req=1 (cycle T); we/funct3/addr/wdata latched then; later input changes are ignored.
REQ-019 Misaligned (h with addr[0]=1, w with addr[1:0]!=0) or undefined funct3 SHALL go IDLE->DONE with misalign=1, done=1 at T+1, no memory access, rdata unchanged.
REQ-020 Load: IDLE->RD->CAP->DONE; mem_addr driven in RD and CAP; lane extracted and sign/zero extended into rdata at end of CAP; done=1 at T+3.
REQ-021 Word store: IDLE->WR->DONE; mem_write=1 for exactly the WR cycle with mem_wdata=wdata; done at T+2; no read.
REQ-022 Sub-word store: IDLE->RD->CAP->WR->DONE; CAP merges wdata low byte/halfword into the fetched word at the addressed lane, other lanes preserved; done at T+4.
REQ-023 Byte lanes SHALL be little-endian: byte k at bits 8k+7:8k, halfword at addr[1]*16.
REQ-024 mem_write SHALL be 1 only in WR; req while busy (including DONE) SHALL be ignored, not queued.
REQ-025 done and misalign SHALL be 0 outside DONE; misalign=0 on successful completion.

Reset
REQ-026 rst low SHALL immediately force state IDLE, rdata=0, done=0, busy=0, misalign=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-027 Reset mid-operation SHALL abandon the access; no write occurs after rst falls, and no done is produced for it.

Structure
REQ-028 State encodings and funct3 constants SHALL live in shared package dm_bridge_pkg.
REQ-029 Lane extract/merge logic SHALL be one combinational sub-module dm_lane; FSM and registers stay in dm_bridge.

Verification
REQ-030 DM word 0x10=0x8899AABB; lb addr 0x11 -> done at T+3, rdata=0xFFFFFFAA, mem_write never 1.
REQ-031 Same memory; lhu addr 0x12 -> rdata=0x00008899 at T+3.
REQ-032 sb addr 0x13 wdata 0x12345677 -> one mem_write cycle at T+3, word 0x10 becomes 0x7799AABB, done at T+4.
REQ-033 sw addr 0x20 wdata 0xDEADBEEF -> mem_write at T+1, word 0x20=0xDEADBEEF, done at T+2.
REQ-034 lw addr 0x22 -> done=1, misalign=1 at T+1, no mem_write, rdata unchanged; req held high during busy is not re-accepted until IDLE.
REQ-035 rst low during RD of sb addr 0x13 -> outputs reset immediately, mem_write never asserts, word 0x10 unchanged, no done.

Source files
------------

// File: rtl/dm_bridge_pkg.sv
// Shared encodings for the CPU-to-data-memory bridge: FSM states, funct3 codes,
// latched request layout and the access legality check.
package dm_bridge_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } dm_req_t;

  // Unsigned sizes only exist for loads, so bu/hu with we=1 count as undefined.
  function automatic logic is_bad_access(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Little-endian lane logic: extracts and sign/zero-extends a load lane, and
// merges a store byte/halfword into a fetched word. Purely combinational.
module dm_lane
  import dm_bridge_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_sh;
  logic [31:0] w_lane;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_sh   = {i_off, 3'b000};
  assign w_lane = i_word >> w_sh;

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_load = {24'b0, w_lane[7:0]};
      F3_H:    o_load = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_HU:   o_load = {16'b0, w_lane[15:0]};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_ins  = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_mask = 32'h0000_00FF << w_sh;
        w_ins  = {24'b0, i_wdata[7:0]} << w_sh;
      end
      2'b01: begin
        w_mask = 32'h0000_FFFF << w_sh;
        w_ins  = {16'b0, i_wdata[15:0]} << w_sh;
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = i_wdata;
      end
    endcase
    o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
  end

endmodule

// File: rtl/dm_bridge.sv
// CPU load/store bridge to a word-wide data memory with one-cycle read latency.
// Loads 3 cycles, word stores 2, sub-word stores 4 (read-modify-write); req ignored while busy.
module dm_bridge
  import dm_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  dm_req_t     r_req;
  logic        r_bad;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        w_accept;
  logic        w_bad;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && req;
  assign w_bad    = is_bad_access(we, funct3, addr[1:0]);

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_IDLE;
        if (req) begin
          if (w_bad)                   w_next = ST_DONE;
          else if (we && funct3 == F3_W) w_next = ST_WR;
          else                         w_next = ST_RD;
        end
      end
      ST_RD:   w_next = ST_CAP;
      ST_CAP:  w_next = r_req.we ? ST_WR : ST_DONE;
      ST_WR:   w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_bad       <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req.we     <= we;
        r_req.funct3 <= funct3;
        r_req.off    <= addr[1:0];
        r_req.wdata  <= wdata;
        r_bad        <= w_bad;
        // A rejected access leaves the memory-side outputs untouched.
        if (!w_bad) begin
          r_mem_addr  <= {addr[31:2], 2'b00};
          r_mem_wdata <= wdata;
        end
      end
      if (r_state == ST_CAP) begin
        if (r_req.we) r_mem_wdata <= w_merged;
        else          r_rdata     <= w_load;
      end
    end
  end

  dm_lane u_lane (
    .i_funct3 (r_req.funct3),
    .i_off    (r_req.off),
    .i_word   (mem_rdata),
    .i_wdata  (r_req.wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign rdata     = r_rdata;
  assign done      = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign misalign  = (r_state == ST_DONE) && r_bad;
  assign mem_write = (r_state == ST_WR);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dm_bridge.sv
// Bench for dm_bridge: behavioural word memory, scoreboard of expected completions.
module tb_dm_bridge;
  import dm_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        misalign;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_dat = 32'd0;

  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc = -1;
  int done_cnt = 0;
  int n_chk = 0;
  int n_pass = 0;
  int t0 = 0;
  logic [31:0] exp_rd = 32'd0;

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic        mis;
    int          wr;
    int          midx;
    logic [31:0] memv;
  } op_t;

  op_t sb_q[$];

  dm_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .misalign  (misalign),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (mem_write === 1'b1) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    mem_rdata <= mem[mem_addr[7:2]];
  end

  function automatic op_t mk(string nm, logic w, logic [2:0] f, logic [31:0] a,
                             logic [31:0] wd, int lat, logic [31:0] rd, logic mis,
                             int wr, int midx, logic [31:0] memv);
    op_t o;
    o.nm = nm; o.we = w; o.f3 = f; o.a = a; o.wd = wd; o.lat = lat; o.rd = rd;
    o.mis = mis; o.wr = wr; o.midx = midx; o.memv = memv;
    return o;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one request for a single cycle, then scrambles the inputs.
  task automatic issue(input op_t o, input bit hold);
    @(negedge clk);
    req = 1'b1; we = o.we; funct3 = o.f3; addr = o.a; wdata = o.wd;
    t0 = cyc;
    @(negedge clk);
    if (!hold) begin
      req = 1'b0; we = ~o.we; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = ~o.wd;
    end
  endtask

  task automatic wait_done(output int lat);
    int i;
    i = 0;
    lat = -1;
    while (done !== 1'b1 && i < 12) begin
      @(negedge clk);
      i++;
    end
    if (done === 1'b1) lat = cyc - t0;
  endtask

  task automatic test_reset;
    preload(4, 32'h8899_AABB);
    preload(8, 32'h0000_0000);
    @(negedge clk);
    n_chk++; if (rdata !== 32'd0) $display("FAIL reset rdata: got %h want 0", rdata); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (misalign !== 1'b0) $display("FAIL reset misalign: got %b want 0", misalign); else n_pass++;
    n_chk++; if (mem_write !== 1'b0) $display("FAIL reset mem_write: got %b want 0", mem_write); else n_pass++;
    n_chk++; if (mem_addr !== 32'd0) $display("FAIL reset mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_chk++; if (mem_wdata !== 32'd0) $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load;
    op_t ops[7];
    op_t e;
    int  lat;
    int  wc0;
    ops[0] = mk("lb_0x11",  1'b0, F3_B,   32'h11, 32'h0, 3, 32'hFFFF_FFAA, 1'b0, -1, -1, 32'h0);
    ops[1] = mk("lhu_0x12", 1'b0, F3_HU,  32'h12, 32'h0, 3, 32'h0000_8899, 1'b0, -1, -1, 32'h0);
    ops[2] = mk("lh_0x10",  1'b0, F3_H,   32'h10, 32'h0, 3, 32'hFFFF_AABB, 1'b0, -1, -1, 32'h0);
    ops[3] = mk("lbu_0x13", 1'b0, F3_BU,  32'h13, 32'h0, 3, 32'h0000_0088, 1'b0, -1, -1, 32'h0);
    ops[4] = mk("lw_0x10",  1'b0, F3_W,   32'h10, 32'h0, 3, 32'h8899_AABB, 1'b0, -1, -1, 32'h0);
    ops[5] = mk("lh_0x11",  1'b0, F3_H,   32'h11, 32'h0, 1, 32'h8899_AABB, 1'b1, -1, -1, 32'h0);
    ops[6] = mk("l011_0x10",1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h8899_AABB, 1'b1, -1, -1, 32'h0);
    foreach (ops[i]) begin
      wc0 = wr_cnt;
      sb_q.push_back(ops[i]);
      issue(ops[i], 1'b0);
      wait_done(lat);
      e = sb_q.pop_front();
      n_chk++; if (lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", e.nm, lat, e.lat); else n_pass++;
      n_chk++; if (rdata !== e.rd) $display("FAIL %s rdata: got %h want %h", e.nm, rdata, e.rd); else n_pass++;
      n_chk++; if (misalign !== e.mis) $display("FAIL %s misalign: got %b want %b", e.nm, misalign, e.mis); else n_pass++;
      n_chk++; if (wr_cnt !== wc0) $display("FAIL %s writes: got %0d want 0", e.nm, wr_cnt - wc0); else n_pass++;
      exp_rd = e.rd;
    end
  endtask

  // Stores followed by loads that read back what was written.
  task automatic test_store;
    op_t ops[6];
    op_t e;
    int  lat;
    int  wc0;
    int  nwr;
    ops[0] = mk("sb_0x13",  1'b1, F3_B,   32'h13, 32'h1234_5677, 4, 32'h8899_AABB, 1'b0,  3, 4, 32'h7799_AABB);
    ops[1] = mk("sw_0x20",  1'b1, F3_W,   32'h20, 32'hDEAD_BEEF, 2, 32'h8899_AABB, 1'b0,  1, 8, 32'hDEAD_BEEF);
    ops[2] = mk("sh_0x22",  1'b1, F3_H,   32'h22, 32'h1234_CAFE, 4, 32'h8899_AABB, 1'b0,  3, 8, 32'hCAFE_BEEF);
    ops[3] = mk("sbu_0x20", 1'b1, F3_BU,  32'h20, 32'h0000_0055, 1, 32'h8899_AABB, 1'b1, -1, 8, 32'hCAFE_BEEF);
    ops[4] = mk("lw_0x20",  1'b0, F3_W,   32'h20, 32'h0,         3, 32'hCAFE_BEEF, 1'b0, -1, 8, 32'hCAFE_BEEF);
    ops[5] = mk("lbu_0x13", 1'b0, F3_BU,  32'h13, 32'h0,         3, 32'h0000_0077, 1'b0, -1, 4, 32'h7799_AABB);
    foreach (ops[i]) begin
      wc0 = wr_cnt;
      sb_q.push_back(ops[i]);
      issue(ops[i], 1'b0);
      wait_done(lat);
      e = sb_q.pop_front();
      nwr = (e.wr >= 0) ? 1 : 0;
      n_chk++; if (lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", e.nm, lat, e.lat); else n_pass++;
      n_chk++; if (rdata !== e.rd) $display("FAIL %s rdata: got %h want %h", e.nm, rdata, e.rd); else n_pass++;
      n_chk++; if (misalign !== e.mis) $display("FAIL %s misalign: got %b want %b", e.nm, misalign, e.mis); else n_pass++;
      n_chk++; if (wr_cnt - wc0 !== nwr) $display("FAIL %s writes: got %0d want %0d", e.nm, wr_cnt - wc0, nwr); else n_pass++;
      if (e.wr >= 0) begin
        n_chk++; if (wr_cyc - t0 !== e.wr) $display("FAIL %s write_cycle: got T+%0d want T+%0d", e.nm, wr_cyc - t0, e.wr); else n_pass++;
      end
      @(negedge clk);
      n_chk++; if (mem[e.midx] !== e.memv) $display("FAIL %s memory: got %h want %h", e.nm, mem[e.midx], e.memv); else n_pass++;
      exp_rd = e.rd;
    end
  endtask

  // req held high through the whole access: no re-accept until back in IDLE.
  task automatic test_misalign_hold;
    op_t o;
    op_t e;
    int  wc0;
    o = mk("lw_0x22", 1'b0, F3_W, 32'h22, 32'h0, 1, exp_rd, 1'b1, -1, -1, 32'h0);
    wc0 = wr_cnt;
    sb_q.push_back(o);
    sb_q.push_back(o);
    issue(o, 1'b1);
    e = sb_q.pop_front();
    n_chk++; if (done !== 1'b1) $display("FAIL hold_first done: got %b want 1", done); else n_pass++;
    n_chk++; if (misalign !== e.mis) $display("FAIL hold_first misalign: got %b want %b", misalign, e.mis); else n_pass++;
    n_chk++; if (rdata !== e.rd) $display("FAIL hold_first rdata: got %h want %h", rdata, e.rd); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b0) $display("FAIL hold_gap done: got %b want 0", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL hold_gap busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (misalign !== 1'b0) $display("FAIL hold_gap misalign: got %b want 0", misalign); else n_pass++;
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++; if (done !== 1'b1) $display("FAIL hold_again done: got %b want 1", done); else n_pass++;
    n_chk++; if (misalign !== e.mis) $display("FAIL hold_again misalign: got %b want %b", misalign, e.mis); else n_pass++;
    req = 1'b0;
    @(negedge clk);
    n_chk++; if (done !== 1'b0) $display("FAIL hold_end done: got %b want 0", done); else n_pass++;
    n_chk++; if (wr_cnt !== wc0) $display("FAIL hold writes: got %0d want 0", wr_cnt - wc0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    op_t o;
    int  wc0;
    int  dc0;
    o = mk("sb_0x13_rst", 1'b1, F3_B, 32'h13, 32'h0000_0011, 4, 32'h0, 1'b0, -1, 4, 32'h7799_AABB);
    wc0 = wr_cnt;
    dc0 = done_cnt;
    issue(o, 1'b0);
    n_chk++; if (busy !== 1'b1) $display("FAIL rst_mid busy_before: got %b want 1", busy); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (rdata !== 32'd0) $display("FAIL rst_mid rdata: got %h want 0", rdata); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_mid done: got %b want 0", done); else n_pass++;
    n_chk++; if (misalign !== 1'b0) $display("FAIL rst_mid misalign: got %b want 0", misalign); else n_pass++;
    n_chk++; if (mem_write !== 1'b0) $display("FAIL rst_mid mem_write: got %b want 0", mem_write); else n_pass++;
    n_chk++; if (mem_addr !== 32'd0) $display("FAIL rst_mid mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_chk++; if (mem_wdata !== 32'd0) $display("FAIL rst_mid mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++; if (wr_cnt !== wc0) $display("FAIL rst_mid writes: got %0d want 0", wr_cnt - wc0); else n_pass++;
    n_chk++; if (done_cnt !== dc0) $display("FAIL rst_mid done_pulses: got %0d want 0", done_cnt - dc0); else n_pass++;
    n_chk++; if (mem[o.midx] !== o.memv) $display("FAIL rst_mid memory: got %h want %h", mem[o.midx], o.memv); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_load;
    test_store;
    test_misalign_hold;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
